// File: rtl/rv_interrupt_controller_pkg.sv
// rv_interrupt_controller_pkg: shared core constants and interrupt FSM state type
package rv_interrupt_controller_pkg;
    localparam int         DEF_PC_W      = 12;
    localparam logic [6:0] SYSTEM_OPCODE = 7'b1110011;
    typedef enum logic {IDLE, IN_ISR} isr_state_t;
endpackage

// File: rtl/rv_interrupt_controller.sv
// rv_interrupt_controller: single-source non-nesting interrupt entry/return at safe fetch boundaries
// Ports: clk, nrst (async active-high reset), PC/if_opcode (IF instruction),
// interrupt_signal (level line, rising-edge triggered), exe_correction/if_prediction/
// id_sel_pc/if_clk_en (pipeline control flow), sel_ISR/ret_ISR (PC mux pulses),
// ISR_en (inside ISR), ISR_stall (squash IF), save_PC (return address).
module rv_interrupt_controller
    import rv_interrupt_controller_pkg::*;
#(
    parameter logic [6:0] RET_OPCODE = SYSTEM_OPCODE,
    parameter int         PC_W       = DEF_PC_W
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic [PC_W-1:0] PC,
    input  logic [6:0]      if_opcode,
    input  logic            interrupt_signal,
    input  logic [1:0]      exe_correction,
    input  logic            if_prediction,
    input  logic            id_sel_pc,
    input  logic            if_clk_en,
    output logic            sel_ISR,
    output logic            ret_ISR,
    output logic            ISR_en,
    output logic            ISR_stall,
    output logic [PC_W-1:0] save_PC
);
    isr_state_t state, state_n;
    logic       int_q, pending, safe, rise;
    // A redirect from any stage or a stalled IF makes the fetch boundary unsafe.
    assign safe = if_clk_en & (exe_correction == 2'b00) & ~if_prediction & ~id_sel_pc;
    assign rise = interrupt_signal & ~int_q;
    always_comb begin
        state_n   = state;
        sel_ISR   = 1'b0;
        ret_ISR   = 1'b0;
        ISR_en    = state == IN_ISR;
        sel_ISR   = (state == IDLE) & pending & safe;
        ret_ISR   = (state == IN_ISR) & (if_opcode == RET_OPCODE) & safe;
        ISR_stall = sel_ISR | ret_ISR;
        state_n   = sel_ISR ? IN_ISR : ret_ISR ? IDLE : state;
    end
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state   <= IDLE;
            int_q   <= 1'b0;
            pending <= 1'b0;
            save_PC <= '0;
        end else begin
            state   <= state_n;
            int_q   <= interrupt_signal;
            // A new edge coinciding with entry re-arms the request.
            pending <= rise | (pending & ~sel_ISR);
            if (sel_ISR) save_PC <= PC;
        end
    end
endmodule

// File: tb/tb_rv_interrupt_controller.sv
// tb_rv_interrupt_controller: scoreboard bench for rv_interrupt_controller
module tb_rv_interrupt_controller;
    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic [11:0] pc = '0;
    logic [6:0]  op = '0;
    logic        int_sig = 1'b0;
    logic [1:0]  corr = '0;
    logic        pred = 1'b0;
    logic        idsel = 1'b0;
    logic        clken = 1'b1;
    logic        sel_isr, ret_isr, isr_en, isr_stall;
    logic [11:0] save_pc;
    int          n_checks = 0;
    int          n_pass = 0;

    typedef struct packed {
        logic        sel;
        logic        ret;
        logic        en;
        logic        stall;
        logic [11:0] save;
    } exp_t;
    exp_t sb[$];

    localparam logic [6:0] RET = 7'b1110011;

    always #5 clk = ~clk;

    rv_interrupt_controller dut (
        .clk(clk), .nrst(nrst), .PC(pc), .if_opcode(op),
        .interrupt_signal(int_sig), .exe_correction(corr),
        .if_prediction(pred), .id_sel_pc(idsel), .if_clk_en(clken),
        .sel_ISR(sel_isr), .ret_ISR(ret_isr), .ISR_en(isr_en),
        .ISR_stall(isr_stall), .save_PC(save_pc)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // One cycle: drive inputs after the falling edge, queue the expectation,
    // then compare the DUT's outputs ahead of the next rising edge.
    task automatic step(input logic r, input logic i, input logic [11:0] p, input logic [6:0] o,
                        input logic [1:0] c, input logic pr, input logic js, input logic ce,
                        input logic e_sel, input logic e_ret, input logic e_en,
                        input logic e_stall, input logic [11:0] e_save);
        exp_t e;
        @(negedge clk);
        nrst = r; int_sig = i; pc = p; op = o; corr = c; pred = pr; idsel = js; clken = ce;
        sb.push_back('{sel: e_sel, ret: e_ret, en: e_en, stall: e_stall, save: e_save});
        #2;
        e = sb.pop_front();
        check("sel_ISR",   {15'd0, sel_isr},   {15'd0, e.sel});
        check("ret_ISR",   {15'd0, ret_isr},   {15'd0, e.ret});
        check("ISR_en",    {15'd0, isr_en},    {15'd0, e.en});
        check("ISR_stall", {15'd0, isr_stall}, {15'd0, e.stall});
        check("save_PC",   {4'd0, save_pc},    {4'd0, e.save});
    endtask

    initial begin
        // reset held two cycles, then released with the line low
        step(1, 0, 12'd0, 7'd0, 2'd0, 0, 0, 1,  0, 0, 0, 0, 12'd0);
        step(1, 0, 12'd0, 7'd0, 2'd0, 0, 0, 1,  0, 0, 0, 0, 12'd0);
        step(0, 0, 12'd8, 7'd0, 2'd0, 0, 0, 1,  0, 0, 0, 0, 12'd0);
        // basic entry: edge sampled, then sel_ISR next cycle
        step(0, 1, 12'd8, 7'd0, 2'd0, 0, 0, 1,  0, 0, 0, 0, 12'd0);
        step(0, 1, 12'd8, 7'd0, 2'd0, 0, 0, 1,  1, 0, 0, 1, 12'd0);
        step(0, 1, 12'd8, 7'd0, 2'd0, 0, 0, 1,  0, 0, 1, 0, 12'd8);
        step(0, 1, 12'd9, 7'd0, 2'd0, 0, 0, 1,  0, 0, 1, 0, 12'd8);
        // return opcode ignored while IF stalled, taken when safe
        step(0, 1, 12'd9, RET,  2'd0, 0, 0, 0,  0, 0, 1, 0, 12'd8);
        step(0, 1, 12'd9, RET,  2'd0, 0, 0, 1,  0, 1, 1, 1, 12'd8);
        step(0, 0, 12'd8, 7'd0, 2'd0, 0, 0, 1,  0, 0, 0, 0, 12'd8);
        step(0, 0, 12'd8, 7'd0, 2'd0, 0, 0, 1,  0, 0, 0, 0, 12'd8);
        // deferred entry: jump redirect plus IF stall for 3 cycles
        step(0, 1, 12'd20, 7'd0, 2'd0, 0, 1, 0, 0, 0, 0, 0, 12'd8);
        step(0, 1, 12'd21, 7'd0, 2'd0, 0, 1, 0, 0, 0, 0, 0, 12'd8);
        step(0, 1, 12'd22, 7'd0, 2'd0, 0, 1, 0, 0, 0, 0, 0, 12'd8);
        step(0, 1, 12'd24, 7'd0, 2'd0, 0, 0, 1, 1, 0, 0, 1, 12'd8);
        step(0, 1, 12'd30, 7'd0, 2'd0, 0, 0, 1, 0, 0, 1, 0, 12'd24);
        step(0, 1, 12'd31, RET,  2'd0, 0, 0, 1, 0, 1, 1, 1, 12'd24);
        step(0, 0, 12'd24, 7'd0, 2'd0, 0, 0, 1, 0, 0, 0, 0, 12'd24);
        // mispredict block: correction, then prediction, then clear
        step(0, 1, 12'd36, 7'd0, 2'd1, 0, 0, 1, 0, 0, 0, 0, 12'd24);
        step(0, 1, 12'd37, 7'd0, 2'd1, 0, 0, 1, 0, 0, 0, 0, 12'd24);
        step(0, 1, 12'd38, 7'd0, 2'd0, 1, 0, 1, 0, 0, 0, 0, 12'd24);
        step(0, 1, 12'd40, 7'd0, 2'd0, 0, 0, 1, 1, 0, 0, 1, 12'd24);
        step(0, 1, 12'd50, 7'd0, 2'd0, 0, 0, 1, 0, 0, 1, 0, 12'd40);
        // no nesting: second edge inside ISR waits for the return
        step(0, 0, 12'd51, 7'd0, 2'd0, 0, 0, 1, 0, 0, 1, 0, 12'd40);
        step(0, 1, 12'd52, 7'd0, 2'd0, 0, 0, 1, 0, 0, 1, 0, 12'd40);
        step(0, 1, 12'd53, 7'd0, 2'd0, 0, 0, 1, 0, 0, 1, 0, 12'd40);
        step(0, 1, 12'd54, RET,  2'd0, 0, 0, 1, 0, 1, 1, 1, 12'd40);
        step(0, 1, 12'd44, 7'd0, 2'd0, 0, 0, 1, 1, 0, 0, 1, 12'd40);
        step(0, 1, 12'd60, 7'd0, 2'd0, 0, 0, 1, 0, 0, 1, 0, 12'd44);
        // reset mid-ISR with a request pending drops everything
        step(0, 0, 12'd61, 7'd0, 2'd0, 0, 0, 1, 0, 0, 1, 0, 12'd44);
        step(0, 1, 12'd62, 7'd0, 2'd0, 0, 0, 1, 0, 0, 1, 0, 12'd44);
        step(1, 0, 12'd63, 7'd0, 2'd0, 0, 0, 1, 0, 0, 0, 0, 12'd0);
        step(0, 0, 12'd64, 7'd0, 2'd0, 0, 0, 1, 0, 0, 0, 0, 12'd0);
        step(0, 0, 12'd65, 7'd0, 2'd0, 0, 0, 1, 0, 0, 0, 0, 12'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/rv_interrupt_controller.md
# rv_interrupt_controller

Single-source, non-nesting interrupt controller for the pipelined RV32IMC core. It sits beside the fetch stage and watches the external interrupt line and the pipeline's control-flow signals. At a safe fetch boundary it redirects the PC mux to the ISR and saves the interrupted fetch PC. It restores that PC when the ISR's return instruction reaches IF.

## Interface
Parameters:
- `RET_OPCODE`, default 7'b1110011 (SYSTEM, MRET/URET): IF opcode that ends the ISR.
- `PC_W`, default 12: PC width.

Ports:
- `clk`, in, 1: clock; all state changes on the rising edge.
- `nrst`, in, 1: reset, asynchronous, active-high (1 = reset).
- `PC`, in, PC_W: PC of the instruction currently in IF.
- `if_opcode`, in, 7: opcode field of the IF instruction.
- `interrupt_signal`, in, 1: external interrupt request, level input, rising-edge triggered.
- `exe_correction`, in, 2: nonzero = EXE is correcting a branch misprediction this cycle.
- `if_prediction`, in, 1: IF predicted a taken branch this cycle.
- `id_sel_pc`, in, 1: ID is redirecting the PC (jump) this cycle.
- `if_clk_en`, in, 1: IF stage advancing (0 = pipeline stalled).
- `sel_ISR`, out, 1: one-cycle pulse; PC mux loads the ISR base address.
- `ret_ISR`, out, 1: one-cycle pulse; PC mux loads `save_PC`.
- `ISR_en`, out, 1: high while executing inside the ISR.
- `ISR_stall`, out, 1: squash the IF instruction this cycle (bubble into ID).
- `save_PC`, out, PC_W: return address.

## Operation
- Edge detect: `int_q` is the registered `interrupt_signal`. A rising edge (`interrupt_signal & ~int_q`) sets `pending`.
- `pending` holds until serviced. Edges that arrive while `pending` is already set are merged into it.
- `safe` = `if_clk_en & (exe_correction == 0) & ~if_prediction & ~id_sel_pc`.
- FSM has two states, IDLE and IN_ISR.
  - IDLE: if `pending & safe`, then assert `sel_ISR` and `ISR_stall` combinationally, capture `save_PC <= PC`, clear `pending`, and go to IN_ISR. Otherwise hold.
  - IN_ISR: `ISR_en = 1`. If `if_opcode == RET_OPCODE & safe`, assert `ret_ISR` and `ISR_stall` combinationally and go to IDLE. Otherwise hold.
- No nesting. A rising edge during IN_ISR sets `pending`, and it is serviced after the return.
- The interrupted IF instruction is squashed, so `save_PC` points at an unexecuted instruction, which is re-fetched on return.
- `save_PC` changes only on entry and holds its value otherwise, including after return.
- `sel_ISR` and `ret_ISR` are never high in the same cycle.

## Timing
- Reset (async, `nrst = 1`): state=IDLE, `pending=0`, `int_q=0`, `save_PC=0`. All outputs read 0 during reset.
- Latency from a rising edge at edge N to `sel_ISR`:
  - Earliest: the `pending` register is set at edge N, and `sel_ISR` is asserted in cycle N+1 if `safe`.
  - Otherwise `sel_ISR` waits for the first cycle with `safe` high.
- `ISR_en` rises the cycle after `sel_ISR` and falls the cycle after `ret_ISR`.
- While `safe` is low, entry or return is deferred with no loss of the request. An IF stall (`if_clk_en = 0`) blocks both entry and return.
- A rising edge in the same cycle as `sel_ISR` (possible only if the line dropped and re-rose) sets `pending` again.
- A reset mid-ISR returns to IDLE. The pending interrupt is dropped and `save_PC` is cleared.

## Structure
- Shared core package: `PC_W`, SYSTEM/return opcode constant, FSM state enum `{IDLE, IN_ISR}`.
- Single flat module; no sub-modules. The edge detector is inline (one flop).

## Test plan
- Reset: `nrst = 1` for 2 cycles, then release with `interrupt_signal` low. Required: all outputs 0 and `save_PC = 0`.
- Basic entry: `interrupt_signal` 0→1 with `safe` held (`if_clk_en=1`, others 0) and `PC=12'd8`.
  - `sel_ISR` and `ISR_stall` pulse one cycle after the edge.
  - `save_PC = 8` from the next cycle, and `ISR_en = 1`.
  - Holding `interrupt_signal` high does not retrigger.
- Deferred entry: rising edge while `id_sel_pc=1` and `if_clk_en=0` for 3 cycles. Required: no `sel_ISR` during those cycles. `sel_ISR` asserts in the first cycle with `safe` high, and `save_PC` equals the PC in that cycle.
- Mispredict block: `pending` set with `exe_correction=2'b01`, then `if_prediction=1`. Required: no entry until both are cleared.
- Return: in IN_ISR, `if_opcode=7'b1110011` with `safe` high.
  - `ret_ISR` and `ISR_stall` pulse one cycle, and `ISR_en` falls the next cycle.
  - `save_PC` is unchanged.
  - The same opcode while `if_clk_en=0` is ignored.
- No nesting: a second rising edge during IN_ISR gives no `sel_ISR` until after `ret_ISR`. A new entry follows on the first `safe` cycle in IDLE.
